// File: rtl/shifter_pkg.sv
// Shared definitions for the multi-cycle right shifter: default geometry,
// derived widths and the control FSM encoding.
package shifter_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_STEP  = 8;

    localparam int SHW    = $clog2(DEF_WIDTH);
    localparam int STEP_W = $clog2(DEF_STEP) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Number of BUSY cycles a request occupies; a zero shift still takes one.
    function automatic int busy_cycles(input int shamt, input int step);
        return (shamt == 0) ? 1 : (shamt + step - 1) / step;
    endfunction

endpackage

// File: rtl/shift_step_r.sv
// Combinational right shift of WIDTH bits by k (0..STEP), vacated top bits
// taken from fill_i. One instance serves every BUSY cycle.
module shift_step_r #(
    parameter int WIDTH = 32,
    parameter int KW    = 4
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [KW-1:0]    k_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] data_o
);

    // Prepend a full word of fill so any k up to WIDTH pulls fill into the top.
    always_comb begin
        data_o = WIDTH'({{WIDTH{fill_i}}, data_i} >> k_i);
    end

endmodule

// File: rtl/shifter_right_seq_32.sv
// Multi-cycle logical/arithmetic right shifter with valid/ready on both sides;
// shifts at most STEP positions per BUSY cycle.
module shifter_right_seq_32
    import shifter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int STEP  = DEF_STEP
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     arith,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    input  logic [WIDTH-1:0]         datain,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         dataout
);

    localparam int SW = $clog2(WIDTH);
    localparam int KW = $clog2(STEP) + 1;
    localparam int CW = (SW > KW) ? SW : KW;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [SW-1:0]    rem_q, rem_d;
    logic             fill_q, fill_d;

    logic [CW-1:0]    rem_ext, k_ext;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] shifted;

    // k = min(rem, STEP), compared in a width wide enough for both operands.
    always_comb begin
        rem_ext = CW'(rem_q);
        k_ext   = (rem_ext > CW'(STEP)) ? CW'(STEP) : rem_ext;
        k       = KW'(k_ext);
    end

    shift_step_r #(
        .WIDTH (WIDTH),
        .KW    (KW)
    ) u_step (
        .data_i (data_q),
        .k_i    (k),
        .fill_i (fill_q),
        .data_o (shifted)
    );

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        dout_d    = dout_q;
        rem_d     = rem_q;
        fill_d    = fill_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d  = datain;
                    rem_d   = shamt;
                    fill_d  = arith & datain[WIDTH-1];
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                data_d = shifted;
                rem_d  = rem_q - SW'(k_ext);
                // Result register only moves on entry to DONE so it stays put elsewhere.
                if (rem_d == '0) begin
                    dout_d  = shifted;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            dout_q  <= '0;
            rem_q   <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            dout_q  <= dout_d;
            rem_q   <= rem_d;
            fill_q  <= fill_d;
        end
    end

    assign dataout = dout_q;

endmodule

// File: tb/tb_shifter_right_seq_32.sv
// Directed and random checks of the multi-cycle right shifter against a
// plain-arithmetic reference (>> / >>> and ceil-divided latency).
module tb_shifter_right_seq_32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        arith = 1'b0;
    logic [4:0]  shamt = '0;
    logic [31:0] datain = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] dataout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    shifter_right_seq_32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .arith     (arith),
        .shamt     (shamt),
        .datain    (datain),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dataout   (dataout)
    );

    function automatic logic [31:0] ref_shift(input logic a, input int s, input logic [31:0] d);
        if (a) return 32'($signed(d) >>> s);
        return d >> s;
    endfunction

    function automatic int ref_lat(input int s);
        return (s == 0) ? 1 : (s + 7) / 8;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request end to end: accept, latency, result, optional backpressure, release.
    task automatic do_op(input logic a, input int s, input logic [31:0] d, input int hold);
        logic [31:0] exp;
        int lat;
        exp = ref_shift(a, s, d);
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; arith = a; shamt = 5'(s); datain = d;
        @(posedge clk); #1;
        check("in_ready_busy", 32'(in_ready), 32'd0);
        // Post-accept input changes must be ignored.
        in_valid = 1'b0; arith = ~a; shamt = 5'($urandom); datain = $urandom;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(ref_lat(s)));
        check("result", dataout, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1; datain = $urandom; shamt = 5'($urandom);
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", dataout, exp);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_hs_valid", 32'(out_valid), 32'd0);
        check("post_hs_in_ready", 32'(in_ready), 32'd1);
        check("post_hs_data", dataout, exp);
    endtask

    initial begin
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_dataout", dataout, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(1'b0, 31, 32'h80000000, 0);
        check("t1_value", dataout, 32'h00000001);
        do_op(1'b1, 4, 32'h80000000, 0);
        check("t2_value", dataout, 32'hF8000000);
        do_op(1'b1, 9, 32'h7FFFFFFF, 0);
        check("t3_value", dataout, 32'h003FFFFF);
        do_op(1'b0, 0, 32'hDEADBEEF, 0);
        do_op(1'b1, 0, 32'hDEADBEEF, 0);
        check("t4_value", dataout, 32'hDEADBEEF);
        do_op(1'b1, 17, 32'h9ABCDEF0, 5);
        do_op(1'b1, 8, 32'hFFFF0000, 0);
        do_op(1'b0, 16, 32'hFFFF0000, 1);
        do_op(1'b1, 24, 32'h80000001, 0);
        do_op(1'b1, 25, 32'hC0000000, 0);

        // Reset in the middle of a long shift.
        @(negedge clk);
        in_valid = 1'b1; arith = 1'b0; shamt = 5'd31; datain = 32'hFFFFFFFF;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("midrst_no_valid", 32'(out_valid), 32'd0);
            check("midrst_ready", 32'(in_ready), 32'd1);
        end
        do_op(1'b0, 1, 32'h00000002, 0);
        check("t6_value", dataout, 32'h00000001);

        for (int n = 0; n < 40; n++) begin
            do_op(1'($urandom), int'($urandom_range(0, 31)), $urandom, int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
